fp8_driver: RTL

Synthesizable stimulus initiator for the `fp8` arithmetic unit: it drives `a`, `b` and `op` into the unit and collects `result` and `flags` back. On `start` it issues a programmable number of pseudo-random operations, one per cycle. It compresses every returned result and flag set into a signature and accumulates flag statistics. It sits between a control/status interface and an `fp8` instance, and serves as on-chip BIST and as the bring-up driver for the unit.

---
 rtl/fp8_driver_if.sv | 16 +
 rtl/fp8_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp8_driver_if.sv
// rtl/fp8_driver_if.sv - operand/result bus between fp8_driver and an fp8 unit
// Signals:
//   a, b    operands driven by the driver (master)
//   op      opcode driven by the driver: 00 add, 01 sub, 10 mul, 11 div
//   result  result returned by the fp8 unit (slave)
//   flags   {invalid, divzero, overflow, underflow, inexact} from the fp8 unit
interface fp8_driver_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic [7:0] result;
  logic [4:0] flags;

  modport master (output a, b, op, input result, flags);
  modport slave  (input a, b, op, output result, flags);
endinterface

// File: rtl/fp8_driver.sv
// rtl/fp8_driver.sv - pseudo-random stimulus driver and response compactor for fp8
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         begin a run (sampled only in IDLE)
//   num_ops       operations per run, 0 means 256
//   seed          LFSR seed loaded on start, 0 means 16'hACE1
//   op_sel        bit2=1: fixed op op_sel[1:0]; bit2=0: op follows issue index
//   fpu           operand/opcode out, result/flags in (fp8_driver_if master)
//   busy          high while issuing or draining
//   done          one-cycle pulse at end of run
//   signature     MISR over returned {flags, result}
//   sticky_flags  OR of all returned flags
//   flag_cnt      number of returned ops with any flag set
module fp8_driver #(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   num_ops,
  input  logic [15:0]  seed,
  input  logic [2:0]   op_sel,
  fp8_driver_if.master fpu,
  output logic         busy,
  output logic         done,
  output logic [15:0]  signature,
  output logic [4:0]   sticky_flags,
  output logic [8:0]   flag_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [2:0]  DRAIN_LAST   = 3'(LATENCY - 1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [8:0]           remain_q, remain_d;
  logic [1:0]           idx_q, idx_d;
  logic [2:0]           drain_q, drain_d;
  logic [LATENCY-1:0]   dl_q, dl_d;
  logic [7:0]           a_q, a_d;
  logic [7:0]           b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic [15:0]          sig_q, sig_d;
  logic [4:0]           sticky_q, sticky_d;
  logic [8:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [15:0]          seed_eff;
  logic                 capture;
  logic                 fb_s;

  // Operand registers always hold what is on the bus in the current cycle,
  // so the LFSR runs one step ahead: on start the first operand pair is
  // taken straight from the seed and lfsr_q holds the pair for the next cycle.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    dl_d     = dl_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sig_d    = sig_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    seed_eff = (seed == 16'h0) ? SEED_DEFAULT : seed;

    // Valid delay line: the tail bit marks the cycle where the fp8 output
    // belongs to an op issued LATENCY cycles earlier.
    dl_d[0] = (state_q == ISSUE);
    for (int k = 1; k < LATENCY; k++) begin
      dl_d[k] = dl_q[k-1];
    end
    capture = dl_q[LATENCY-1];
    fb_s    = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];

    if (capture) begin
      sig_d    = {sig_q[14:0], fb_s} ^ {3'b000, fpu.flags, fpu.result};
      sticky_d = sticky_q | fpu.flags;
      cnt_d    = cnt_q + {8'h00, |fpu.flags};
    end

    case (state_q)
      IDLE: begin
        a_d  = 8'h00;
        b_d  = 8'h00;
        op_d = 2'b00;
        if (start) begin
          a_d      = seed_eff[15:8];
          b_d      = seed_eff[7:0];
          op_d     = op_sel[2] ? op_sel[1:0] : 2'b00;
          lfsr_d   = lfsr_step(seed_eff);
          idx_d    = 2'd1;
          remain_d = (num_ops == 8'h00) ? 9'd256 : {1'b0, num_ops};
          sig_d    = 16'h0000;
          sticky_d = 5'b00000;
          cnt_d    = 9'd0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // remain_q counts the op currently on the bus, so 1 means last issue
        if (remain_q == 9'd1) begin
          a_d      = 8'h00;
          b_d      = 8'h00;
          op_d     = 2'b00;
          remain_d = 9'd0;
          drain_d  = DRAIN_LAST;
          state_d  = DRAIN;
        end else begin
          a_d      = lfsr_q[15:8];
          b_d      = lfsr_q[7:0];
          op_d     = op_sel[2] ? op_sel[1:0] : idx_q;
          lfsr_d   = lfsr_step(lfsr_q);
          idx_d    = idx_q + 2'd1;
          remain_d = remain_q - 9'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_DEFAULT;
      remain_q <= 9'd0;
      idx_q    <= 2'd0;
      drain_q  <= 3'd0;
      dl_q     <= '0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 2'b00;
      sig_q    <= 16'h0000;
      sticky_q <= 5'b00000;
      cnt_q    <= 9'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      dl_q     <= dl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sig_q    <= sig_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign fpu.a        = a_q;
  assign fpu.b        = b_q;
  assign fpu.op       = op_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign signature    = sig_q;
  assign sticky_flags = sticky_q;
  assign flag_cnt     = cnt_q;

endmodule
